// File: rtl/id_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : id_ctrl_pipe
// Purpose  : RV32 ID-stage decoder with the ID/EX pipeline register.
//            Decodes the instruction, detects load-use hazards and traps,
//            and registers the control bundle into EX with 1-cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
module id_ctrl_pipe #(
  parameter logic EN_M   = 1'b0,
  parameter logic EN_SYS = 1'b1,
  parameter int   CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      pc_i,
  input  logic             id_valid_i,
  input  logic             ex_stall_i,
  input  logic             flush_i,
  output logic             id_stall_o,
  output logic             ex_valid_o,
  output logic [31:0]      ex_pc_o,
  output logic [4:0]       ex_rd_o,
  output logic [4:0]       ex_rs1_o,
  output logic [4:0]       ex_rs2_o,
  output logic [39:0]      ex_ctrl_o,
  output logic             ex_exc_o,
  output logic [3:0]       ex_cause_o,
  output logic [31:0]      ex_tval_o,
  output logic             ex_mret_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // Decoder field encodings
  localparam logic [2:0] C_SEXT_I = 3'd1, C_SEXT_S = 3'd2, C_SEXT_B = 3'd3,
                         C_SEXT_U = 3'd4, C_SEXT_J = 3'd5, C_SEXT_Z = 3'd6;
  localparam logic [1:0] C_NPC_PC4 = 2'd0, C_NPC_BR = 2'd1, C_NPC_JAL = 2'd2, C_NPC_JALR = 2'd3;
  localparam logic [3:0] C_ALU_ADD = 4'd0, C_ALU_SUB = 4'd1, C_ALU_SLL = 4'd2, C_ALU_SLT = 4'd3,
                         C_ALU_SLTU = 4'd4, C_ALU_XOR = 4'd5, C_ALU_SRL = 4'd6, C_ALU_SRA = 4'd7,
                         C_ALU_OR = 4'd8, C_ALU_AND = 4'd9;
  localparam logic [2:0] C_WSEL_ALU = 3'd0, C_WSEL_MEM = 3'd1, C_WSEL_PC4 = 3'd2,
                         C_WSEL_IMM = 3'd3, C_WSEL_CSR = 3'd4;
  localparam logic [3:0] C_CAUSE_ILL = 4'd2, C_CAUSE_BRK = 4'd3, C_CAUSE_ECALL = 4'd11;

  typedef struct packed {
    logic [2:0] sext_op;
    logic [1:0] npc_op;
    logic       ram_we;
    logic [1:0] ram_w_op;
    logic [2:0] mem_ext_op;
    logic [3:0] alu_op;
    logic [2:0] alu_f_op;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic       rd1_en;
    logic       rd2_en;
    logic       rf_we;
    logic [2:0] rf_wsel;
    logic       is_load;
    logic       csr_we;
    logic       csr_wdata_sel;
    logic [1:0] csr_wdata_op;
    logic       mdu_en;
  } ctrl_t;

  ctrl_t       dec;
  logic        illegal, is_ecall, is_ebreak, is_mret, hazard;
  logic        dec_exc;
  logic [3:0]  dec_cause;
  logic [31:0] dec_tval;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;

  logic             ex_valid_q, ex_valid_d, ex_exc_q, ex_exc_d, ex_mret_q, ex_mret_d;
  logic [31:0]      ex_pc_q, ex_pc_d, ex_tval_q, ex_tval_d;
  logic [4:0]       ex_rd_q, ex_rd_d, ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic [39:0]      ex_ctrl_q, ex_ctrl_d;
  logic [3:0]       ex_cause_q, ex_cause_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign opcode = inst_i[6:0];
  assign f3     = inst_i[14:12];
  assign f7     = inst_i[31:25];

  // Instruction decode: control bundle plus illegal/system classification
  always_comb begin
    dec       = '0;
    illegal   = 1'b0;
    is_ecall  = 1'b0;
    is_ebreak = 1'b0;
    is_mret   = 1'b0;
    case (opcode)
      7'b0110011: begin
        dec.rd1_en = 1'b1; dec.rd2_en = 1'b1; dec.rf_we = 1'b1; dec.rf_wsel = C_WSEL_ALU;
        if (f7 == 7'b0000001) begin
          if (EN_M) begin dec.mdu_en = 1'b1; dec.alu_op = {1'b0, f3}; end
          else illegal = 1'b1;
        end else if (f7 == 7'b0000000) begin
          case (f3)
            3'b000: dec.alu_op = C_ALU_ADD;  3'b001: dec.alu_op = C_ALU_SLL;
            3'b010: dec.alu_op = C_ALU_SLT;  3'b011: dec.alu_op = C_ALU_SLTU;
            3'b100: dec.alu_op = C_ALU_XOR;  3'b101: dec.alu_op = C_ALU_SRL;
            3'b110: dec.alu_op = C_ALU_OR;   default: dec.alu_op = C_ALU_AND;
          endcase
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'b000)      dec.alu_op = C_ALU_SUB;
          else if (f3 == 3'b101) dec.alu_op = C_ALU_SRA;
          else                   illegal = 1'b1;
        end else illegal = 1'b1;
      end
      7'b0010011: begin
        dec.sext_op = C_SEXT_I; dec.alu_b_sel = 1'b1; dec.rd1_en = 1'b1; dec.rf_we = 1'b1;
        case (f3)
          3'b000: dec.alu_op = C_ALU_ADD;  3'b010: dec.alu_op = C_ALU_SLT;
          3'b011: dec.alu_op = C_ALU_SLTU; 3'b100: dec.alu_op = C_ALU_XOR;
          3'b110: dec.alu_op = C_ALU_OR;   3'b111: dec.alu_op = C_ALU_AND;
          3'b001: begin
            dec.alu_op = C_ALU_SLL;
            if (f7 != 7'b0000000) illegal = 1'b1;
          end
          default: begin
            if (f7 == 7'b0000000)      dec.alu_op = C_ALU_SRL;
            else if (f7 == 7'b0100000) dec.alu_op = C_ALU_SRA;
            else                       illegal = 1'b1;
          end
        endcase
      end
      7'b0000011: begin
        dec.sext_op = C_SEXT_I; dec.alu_b_sel = 1'b1; dec.rd1_en = 1'b1; dec.rf_we = 1'b1;
        dec.rf_wsel = C_WSEL_MEM; dec.is_load = 1'b1;
        case (f3)
          3'b000: dec.mem_ext_op = 3'd0; 3'b001: dec.mem_ext_op = 3'd1;
          3'b010: dec.mem_ext_op = 3'd2; 3'b100: dec.mem_ext_op = 3'd3;
          3'b101: dec.mem_ext_op = 3'd4; default: illegal = 1'b1;
        endcase
      end
      7'b0100011: begin
        dec.sext_op = C_SEXT_S; dec.alu_b_sel = 1'b1; dec.rd1_en = 1'b1; dec.rd2_en = 1'b1;
        dec.ram_we = 1'b1; dec.ram_w_op = f3[1:0];
        if (f3[2] || f3[1:0] == 2'b11) illegal = 1'b1;
      end
      7'b1100011: begin
        dec.sext_op = C_SEXT_B; dec.npc_op = C_NPC_BR; dec.rd1_en = 1'b1; dec.rd2_en = 1'b1;
        dec.alu_op = C_ALU_SUB;
        case (f3)
          3'b000: dec.alu_f_op = 3'd0; 3'b001: dec.alu_f_op = 3'd1;
          3'b100: dec.alu_f_op = 3'd2; 3'b101: dec.alu_f_op = 3'd3;
          3'b110: dec.alu_f_op = 3'd4; 3'b111: dec.alu_f_op = 3'd5;
          default: illegal = 1'b1;
        endcase
      end
      7'b1101111: begin
        dec.sext_op = C_SEXT_J; dec.npc_op = C_NPC_JAL; dec.rf_we = 1'b1; dec.rf_wsel = C_WSEL_PC4;
      end
      7'b1100111: begin
        dec.sext_op = C_SEXT_I; dec.npc_op = C_NPC_JALR; dec.rd1_en = 1'b1; dec.alu_b_sel = 1'b1;
        dec.rf_we = 1'b1; dec.rf_wsel = C_WSEL_PC4;
        if (f3 != 3'b000) illegal = 1'b1;
      end
      7'b0110111: begin
        dec.sext_op = C_SEXT_U; dec.rf_we = 1'b1; dec.rf_wsel = C_WSEL_IMM;
      end
      7'b0010111: begin
        dec.sext_op = C_SEXT_U; dec.alu_a_sel = 1'b1; dec.alu_b_sel = 1'b1; dec.rf_we = 1'b1;
      end
      7'b1110011: begin
        if (f3 == 3'b000) begin
          if (!EN_SYS)                        illegal   = 1'b1;
          else if (inst_i[31:20] == 12'h000)  is_ecall  = 1'b1;
          else if (inst_i[31:20] == 12'h001)  is_ebreak = 1'b1;
          else if (inst_i[31:20] == 12'h302)  is_mret   = 1'b1;
          else                                illegal   = 1'b1;
        end else if (f3 == 3'b100) begin
          illegal = 1'b1;
        end else begin
          dec.rf_we = 1'b1; dec.rf_wsel = C_WSEL_CSR; dec.csr_we = 1'b1;
          dec.csr_wdata_op = f3[1:0];
          if (f3[2]) begin dec.csr_wdata_sel = 1'b1; dec.sext_op = C_SEXT_Z; end
          else       dec.rd1_en = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
    if (inst_i[11:7] == 5'd0) dec.rf_we = 1'b0;
    // Illegal ops keep their operand enables so the hazard check still sees them
    if (illegal) begin
      dec.rf_we = 1'b0; dec.ram_we = 1'b0; dec.csr_we = 1'b0; dec.mdu_en = 1'b0;
      dec.npc_op = C_NPC_PC4;
    end
  end

  assign dec_exc   = illegal | is_ecall | is_ebreak;
  assign dec_cause = illegal ? C_CAUSE_ILL : (is_ebreak ? C_CAUSE_BRK : (is_ecall ? C_CAUSE_ECALL : 4'd0));
  assign dec_tval  = illegal ? inst_i : 32'd0;

  assign hazard = id_valid_i & ex_valid_q & ex_ctrl_q[5] & (ex_rd_q != 5'd0) &
                  ((dec.rd1_en & (inst_i[19:15] == ex_rd_q)) |
                   (dec.rd2_en & (inst_i[24:20] == ex_rd_q)));

  assign id_stall_o = (hazard | ex_stall_i) & ~flush_i;

  // ID/EX next state: flush > hold > hazard bubble > load > bubble
  always_comb begin
    ex_valid_d = ex_valid_q; ex_pc_d  = ex_pc_q;  ex_rd_d    = ex_rd_q;
    ex_rs1_d   = ex_rs1_q;   ex_rs2_d = ex_rs2_q; ex_ctrl_d  = ex_ctrl_q;
    ex_exc_d   = ex_exc_q;   ex_cause_d = ex_cause_q; ex_tval_d = ex_tval_q;
    ex_mret_d  = ex_mret_q;
    if (flush_i || (!ex_stall_i && (hazard || !id_valid_i))) begin
      ex_valid_d = 1'b0; ex_pc_d  = '0; ex_rd_d    = '0;
      ex_rs1_d   = '0;   ex_rs2_d = '0; ex_ctrl_d  = '0;
      ex_exc_d   = 1'b0; ex_cause_d = '0; ex_tval_d = '0;
      ex_mret_d  = 1'b0;
    end else if (!ex_stall_i) begin
      ex_valid_d = 1'b1;          ex_pc_d  = pc_i;           ex_rd_d   = inst_i[11:7];
      ex_rs1_d   = inst_i[19:15]; ex_rs2_d = inst_i[24:20];  ex_ctrl_d = {8'd0, dec};
      ex_exc_d   = dec_exc;       ex_cause_d = dec_cause;    ex_tval_d = dec_tval;
      ex_mret_d  = is_mret;
    end
    stall_cnt_d = stall_cnt_q;
    if (hazard && !flush_i && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Pipeline and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0; ex_pc_q  <= '0; ex_rd_q    <= '0;
      ex_rs1_q   <= '0;   ex_rs2_q <= '0; ex_ctrl_q  <= '0;
      ex_exc_q   <= 1'b0; ex_cause_q <= '0; ex_tval_q <= '0;
      ex_mret_q  <= 1'b0; stall_cnt_q <= '0;
    end else begin
      ex_valid_q <= ex_valid_d; ex_pc_q  <= ex_pc_d;  ex_rd_q    <= ex_rd_d;
      ex_rs1_q   <= ex_rs1_d;   ex_rs2_q <= ex_rs2_d; ex_ctrl_q  <= ex_ctrl_d;
      ex_exc_q   <= ex_exc_d;   ex_cause_q <= ex_cause_d; ex_tval_q <= ex_tval_d;
      ex_mret_q  <= ex_mret_d;  stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid_o  = ex_valid_q;
  assign ex_pc_o     = ex_pc_q;
  assign ex_rd_o     = ex_rd_q;
  assign ex_rs1_o    = ex_rs1_q;
  assign ex_rs2_o    = ex_rs2_q;
  assign ex_ctrl_o   = ex_ctrl_q;
  assign ex_exc_o    = ex_exc_q;
  assign ex_cause_o  = ex_cause_q;
  assign ex_tval_o   = ex_tval_q;
  assign ex_mret_o   = ex_mret_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ctrl_pipe
// Purpose  : Directed self-checking bench for id_ctrl_pipe. Two instances
//            share stimulus: dut0 without RV32M, dut1 with RV32M.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst, id_valid, ex_stall, flush;
  logic [31:0] inst, pc;

  logic        id_stall0, ex_valid0, ex_exc0, ex_mret0;
  logic [31:0] ex_pc0, ex_tval0;
  logic [4:0]  ex_rd0, ex_rs10, ex_rs20;
  logic [39:0] ex_ctrl0;
  logic [3:0]  ex_cause0;
  logic [15:0] stall_cnt0;

  logic        id_stall1, ex_valid1, ex_exc1, ex_mret1;
  logic [31:0] ex_pc1, ex_tval1;
  logic [4:0]  ex_rd1, ex_rs11, ex_rs21;
  logic [39:0] ex_ctrl1;
  logic [3:0]  ex_cause1;
  logic [15:0] stall_cnt1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_ctrl_pipe #(.EN_M(1'b0), .EN_SYS(1'b1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .inst_i(inst), .pc_i(pc), .id_valid_i(id_valid),
    .ex_stall_i(ex_stall), .flush_i(flush), .id_stall_o(id_stall0),
    .ex_valid_o(ex_valid0), .ex_pc_o(ex_pc0), .ex_rd_o(ex_rd0), .ex_rs1_o(ex_rs10),
    .ex_rs2_o(ex_rs20), .ex_ctrl_o(ex_ctrl0), .ex_exc_o(ex_exc0), .ex_cause_o(ex_cause0),
    .ex_tval_o(ex_tval0), .ex_mret_o(ex_mret0), .stall_cnt_o(stall_cnt0));

  id_ctrl_pipe #(.EN_M(1'b1), .EN_SYS(1'b1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .inst_i(inst), .pc_i(pc), .id_valid_i(id_valid),
    .ex_stall_i(ex_stall), .flush_i(flush), .id_stall_o(id_stall1),
    .ex_valid_o(ex_valid1), .ex_pc_o(ex_pc1), .ex_rd_o(ex_rd1), .ex_rs1_o(ex_rs11),
    .ex_rs2_o(ex_rs21), .ex_ctrl_o(ex_ctrl1), .ex_exc_o(ex_exc1), .ex_cause_o(ex_cause1),
    .ex_tval_o(ex_tval1), .ex_mret_o(ex_mret1), .stall_cnt_o(stall_cnt1));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Control bundle values derived by hand from the field layout:
  // sext[31:29] npc[28:27] ram_we[26] ram_w_op[25:24] mem_ext[23:21] alu[20:17]
  // alu_f[16:14] a_sel[13] b_sel[12] rd1[11] rd2[10] rf_we[9] wsel[8:6]
  // is_load[5] csr_we[4] csr_sel[3] csr_op[2:1] mdu_en[0]
  initial begin
    rst = 1'b1; id_valid = 1'b0; ex_stall = 1'b0; flush = 1'b0;
    inst = 32'd0; pc = 32'd0;
    tick(); tick();
    check("rst_valid",  ex_valid0, 1'b0);
    check("rst_ctrl",   ex_ctrl0, 40'd0);
    check("rst_cnt",    stall_cnt0, 16'd0);
    check("rst_stall",  id_stall0, 1'b0);
    rst = 1'b0;

    // ADD x3,x1,x2
    inst = 32'h002081B3; pc = 32'h100; id_valid = 1'b1;
    tick();
    check("add_valid", ex_valid0, 1'b1);
    check("add_ctrl",  ex_ctrl0, 40'h00_0000_0E00);
    check("add_rfwe",  ex_ctrl0[9], 1'b1);
    check("add_rd",    ex_rd0, 5'd3);
    check("add_pc",    ex_pc0, 32'h100);
    check("add_exc",   ex_exc0, 1'b0);

    // LW x5,0(x1) followed by dependent ADD x6,x5,x2
    inst = 32'h0000A283; pc = 32'h104;
    tick();
    check("lw_ctrl", ex_ctrl0, 40'h00_2040_1A60);
    check("lw_rd",   ex_rd0, 5'd5);
    inst = 32'h00228333; pc = 32'h108;
    #1;
    check("hz_stall",  id_stall0, 1'b1);
    tick();
    check("hz_bubble", ex_valid0, 1'b0);
    check("hz_bctrl",  ex_ctrl0, 40'd0);
    check("hz_cnt",    stall_cnt0, 16'd1);
    check("hz_nostall", id_stall0, 1'b0);
    tick();
    check("hz_add_valid", ex_valid0, 1'b1);
    check("hz_add_rd",    ex_rd0, 5'd6);
    check("hz_add_pc",    ex_pc0, 32'h108);
    check("hz_cnt_hold",  stall_cnt0, 16'd1);

    // All-ones word is illegal
    inst = 32'hFFFFFFFF; pc = 32'h10C;
    tick();
    check("ill_exc",   ex_exc0, 1'b1);
    check("ill_cause", ex_cause0, 4'd2);
    check("ill_tval",  ex_tval0, 32'hFFFFFFFF);
    check("ill_ctrl",  ex_ctrl0, 40'd0);

    // MUL x1,x2,x3: illegal without RV32M, MDU op with it
    inst = 32'h023100B3; pc = 32'h110;
    tick();
    check("mul0_exc",   ex_exc0, 1'b1);
    check("mul0_cause", ex_cause0, 4'd2);
    check("mul0_tval",  ex_tval0, 32'h023100B3);
    check("mul0_ctrl",  ex_ctrl0, 40'h00_0000_0C00);
    check("mul1_exc",   ex_exc1, 1'b0);
    check("mul1_ctrl",  ex_ctrl1, 40'h00_0000_0E01);

    // ECALL held in EX by ex_stall for 3 cycles, then flushed
    inst = 32'h00000073; pc = 32'h200;
    tick();
    check("ecall_exc",   ex_exc0, 1'b1);
    check("ecall_cause", ex_cause0, 4'd11);
    check("ecall_tval",  ex_tval0, 32'd0);
    ex_stall = 1'b1; inst = 32'h002081B3; pc = 32'h204;
    #1;
    check("hold_idstall", id_stall0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_valid", ex_valid0, 1'b1);
      check("hold_cause", ex_cause0, 4'd11);
      check("hold_pc",    ex_pc0, 32'h200);
      check("hold_ctrl",  ex_ctrl0, 40'd0);
    end
    flush = 1'b1;
    #1;
    check("flush_idstall", id_stall0, 1'b0);
    tick();
    check("flush_valid", ex_valid0, 1'b0);
    check("flush_exc",   ex_exc0, 1'b0);
    check("flush_cause", ex_cause0, 4'd0);
    flush = 1'b0; ex_stall = 1'b0;

    // EBREAK and MRET
    inst = 32'h00100073; pc = 32'h300;
    tick();
    check("ebreak_cause", ex_cause0, 4'd3);
    check("ebreak_exc",   ex_exc0, 1'b1);
    inst = 32'h30200073; pc = 32'h304;
    tick();
    check("mret_flag", ex_mret0, 1'b1);
    check("mret_exc",  ex_exc0, 1'b0);

    // Hold a load-use hazard until the stall counter saturates
    inst = 32'h0000A283; pc = 32'h400;
    tick();
    inst = 32'h00228333; pc = 32'h404; ex_stall = 1'b1;
    repeat (65534) tick();
    check("sat_cnt",   stall_cnt0, 16'hFFFF);
    check("sat_held",  ex_ctrl0, 40'h00_2040_1A60);
    tick();
    check("sat_stay",  stall_cnt0, 16'hFFFF);
    rst = 1'b1;
    tick();
    check("rst_hz_valid", ex_valid0, 1'b0);
    check("rst_hz_ctrl",  ex_ctrl0, 40'd0);
    check("rst_hz_rd",    ex_rd0, 5'd0);
    check("rst_hz_pc",    ex_pc0, 32'd0);
    check("rst_hz_cnt",   stall_cnt0, 16'd0);
    ex_stall = 1'b0;
    #1;
    check("rst_hz_idstall", id_stall0, 1'b0);
    rst = 1'b0;

    // ADDI x0,x0,1: rd=0 suppresses the write enable
    inst = 32'h00100013; pc = 32'h500;
    tick();
    check("addi_x0_valid", ex_valid0, 1'b1);
    check("addi_x0_ctrl",  ex_ctrl0, 40'h00_2000_1800);

    // Empty ID slot inserts a bubble
    id_valid = 1'b0;
    tick();
    check("idle_valid", ex_valid0, 1'b0);
    check("idle_ctrl",  ex_ctrl0, 40'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
